// File: rtl/key_debounce_bank_pkg.sv
// key_debounce_bank_pkg
//   Shared definitions for the key debounce bank: the per-channel state
//   encoding and the default timing constants (50 MHz board clock).
package key_debounce_bank_pkg;

  // Channel state encoding
  localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  typedef enum logic [1:0] {
    IDLE_LOW  = ST_IDLE_LOW,
    WAIT_HIGH = ST_WAIT_HIGH,
    IDLE_HIGH = ST_IDLE_HIGH,
    WAIT_LOW  = ST_WAIT_LOW
  } db_state_e;

  // Default timing: 20 ms of stable input at 50 MHz
  localparam int DEF_WIDTH         = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_CNT_W         = 20;

endpackage

// File: rtl/key_debounce_bank_debounce_bit.sv
// debounce_bit
//   One debounce channel: SYNC_STAGES-deep synchronizer, qualification
//   counter and a four-state FSM. A new level is accepted only after
//   STABLE_CYCLES consecutive identical synchronized samples.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous, active-high
//   Din   - raw asynchronous input (no inversion)
//   DB    - debounced level (registered)
//   Rise  - one-cycle pulse on DB 0->1 (registered)
//   Fall  - one-cycle pulse on DB 1->0 (registered)
//   Busy  - high while a candidate change is being qualified (registered)
module debounce_bit
  import key_debounce_bank_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Din,
  output logic DB,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], Din};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;            // bounce: drop candidate silently
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
    // Level outputs follow the next state so they are registered alongside it
    db_d   = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign DB   = db_q;
  assign Rise = rise_q;
  assign Fall = fall_q;
  assign Busy = busy_q;

endmodule

// File: rtl/key_debounce_bank.sv
// key_debounce_bank
//   Bank of WIDTH independent debounce channels for raw DE2 keys/switches.
//   Produces synchronized debounced levels plus one-cycle edge pulses.
// Ports:
//   Clk   - 50 MHz system clock
//   Reset - asynchronous, active-high
//   Din   - [WIDTH] raw asynchronous inputs
//   DB    - [WIDTH] debounced levels
//   Rise  - [WIDTH] one-cycle pulse on DB 0->1
//   Fall  - [WIDTH] one-cycle pulse on DB 1->0
//   Busy  - [WIDTH] channel qualifying a candidate change
module key_debounce_bank
  import key_debounce_bank_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] DB,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic [WIDTH-1:0] Busy
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_db (
      .Clk  (Clk),
      .Reset(Reset),
      .Din  (Din[i]),
      .DB   (DB[i]),
      .Rise (Rise[i]),
      .Fall (Fall[i]),
      .Busy (Busy[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// tb_key_debounce_bank
//   Directed bench, WIDTH=2, SYNC_STAGES=2, STABLE_CYCLES=4.
//   Edge numbers count rising edges after reset release (edge 1 is the
//   first sampling edge). A value driven just after edge e-1 is sampled at
//   edge e; outputs are checked 1 ns after the named edge.
module tb_key_debounce_bank;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Din;
  logic [1:0] DB, Rise, Fall, Busy;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  key_debounce_bank #(
    .WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(20)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Din(Din),
    .DB(DB), .Rise(Rise), .Fall(Fall), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    ecnt++;
    #1;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Din   = 2'b00;
    tick();
    tick();
    Reset = 1'b0;
    ecnt  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got DB=%b Rise=%b Fall=%b Busy=%b, want all 0", DB, Rise, Fall, Busy);
    end
    run_to(5);
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_reset: got DB=%b Rise=%b Fall=%b Busy=%b, want all 0", DB, Rise, Fall, Busy);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    run_to(9); Din = 2'b01;
    run_to(11);
    checks++;
    if ({DB, Rise, Busy} !== 6'b00_00_00) begin
      errors++;
      $display("FAIL press_e11: got DB=%b Rise=%b Busy=%b, want 00 00 00", DB, Rise, Busy);
    end
    run_to(12);
    checks++;
    if ({DB, Rise, Busy} !== 6'b00_00_01) begin
      errors++;
      $display("FAIL press_busy_e12: got DB=%b Rise=%b Busy=%b, want 00 00 01", DB, Rise, Busy);
    end
    run_to(14);
    checks++;
    if ({DB, Rise, Busy} !== 6'b00_00_01) begin
      errors++;
      $display("FAIL press_e14: got DB=%b Rise=%b Busy=%b, want 00 00 01", DB, Rise, Busy);
    end
    run_to(15);
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'b01_01_00_00) begin
      errors++;
      $display("FAIL press_commit_e15: got DB=%b Rise=%b Fall=%b Busy=%b, want 01 01 00 00", DB, Rise, Fall, Busy);
    end
    run_to(16);
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'b01_00_00_00) begin
      errors++;
      $display("FAIL press_pulse_end_e16: got DB=%b Rise=%b Fall=%b Busy=%b, want 01 00 00 00", DB, Rise, Fall, Busy);
    end
  endtask

  // Pattern 1,1,0 then held 1 from edge 13: the restart is sampled at
  // edge 13, so commit lands at 13 + 2 + 4 - 1 = 18.
  task automatic test_bounce();
    logic [6:0] pat;
    int rises;
    pat   = 7'b1111011;
    rises = 0;
    do_reset();
    run_to(9);
    for (int e = 10; e <= 26; e++) begin
      Din[0] = (e <= 16) ? pat[e-10] : 1'b1;
      tick();
      rises += int'(Rise[0]);
      if (e == 13) begin
        checks++;
        if ({DB[0], Busy[0]} !== 2'b01) begin
          errors++;
          $display("FAIL bounce_busy_e13: got DB=%b Busy=%b, want 0 1", DB[0], Busy[0]);
        end
      end
      if (e == 14) begin
        checks++;
        if ({DB[0], Busy[0]} !== 2'b00) begin
          errors++;
          $display("FAIL bounce_drop_e14: got DB=%b Busy=%b, want 0 0", DB[0], Busy[0]);
        end
      end
      if (e == 15) begin
        checks++;
        if ({DB[0], Rise[0], Busy[0]} !== 3'b001) begin
          errors++;
          $display("FAIL bounce_no_commit_e15: got DB=%b Rise=%b Busy=%b, want 0 0 1", DB[0], Rise[0], Busy[0]);
        end
      end
      if (e == 17) begin
        checks++;
        if ({DB[0], Rise[0]} !== 2'b00) begin
          errors++;
          $display("FAIL bounce_e17: got DB=%b Rise=%b, want 0 0", DB[0], Rise[0]);
        end
      end
      if (e == 18) begin
        checks++;
        if ({DB[0], Rise[0], Busy[0]} !== 3'b110) begin
          errors++;
          $display("FAIL bounce_commit_e18: got DB=%b Rise=%b Busy=%b, want 1 1 0", DB[0], Rise[0], Busy[0]);
        end
      end
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d pulses, want 1", rises);
    end
  endtask

  task automatic test_release();
    do_reset();
    run_to(9); Din = 2'b01;
    run_to(29); Din = 2'b00;
    run_to(32);
    checks++;
    if ({DB, Busy} !== 4'b01_01) begin
      errors++;
      $display("FAIL release_busy_e32: got DB=%b Busy=%b, want 01 01", DB, Busy);
    end
    run_to(34);
    checks++;
    if ({DB, Fall} !== 4'b01_00) begin
      errors++;
      $display("FAIL release_e34: got DB=%b Fall=%b, want 01 00", DB, Fall);
    end
    run_to(35);
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'b00_00_01_00) begin
      errors++;
      $display("FAIL release_commit_e35: got DB=%b Rise=%b Fall=%b Busy=%b, want 00 00 01 00", DB, Rise, Fall, Busy);
    end
    run_to(36);
    checks++;
    if ({DB, Rise, Fall} !== 6'b00_00_00) begin
      errors++;
      $display("FAIL release_pulse_end_e36: got DB=%b Rise=%b Fall=%b, want 00 00 00", DB, Rise, Fall);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    do_reset();
    run_to(9); Din = 2'b01;
    run_to(13);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_immediate: got DB=%b Rise=%b Fall=%b Busy=%b, want all 0", DB, Rise, Fall, Busy);
    end
    tick();
    tick();
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_held: got DB=%b Rise=%b Fall=%b Busy=%b, want all 0", DB, Rise, Fall, Busy);
    end
    Reset = 1'b0;
    ecnt  = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      pulses += int'(Rise[0]) + int'(Fall[0]);
    end
    checks++;
    if ({DB[0], pulses[0]} !== 2'b00 || pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_pre_e5: got DB=%b pulses=%0d, want 0 0", DB[0], pulses);
    end
    run_to(6);
    checks++;
    if ({DB[0], Rise[0]} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_commit_e6: got DB=%b Rise=%b, want 1 1", DB[0], Rise[0]);
    end
  endtask

  task automatic test_simultaneous();
    int ch1_bad;
    ch1_bad = 0;
    do_reset();
    run_to(9); Din = 2'b11;
    run_to(11); Din = 2'b01;
    run_to(12);
    checks++;
    if (Busy !== 2'b11) begin
      errors++;
      $display("FAIL simul_busy_e12: got Busy=%b, want 11", Busy);
    end
    run_to(14);
    checks++;
    if ({DB, Busy} !== 4'b00_01) begin
      errors++;
      $display("FAIL simul_ch1_drop_e14: got DB=%b Busy=%b, want 00 01", DB, Busy);
    end
    run_to(15);
    checks++;
    if ({DB, Rise, Fall, Busy} !== 8'b01_01_00_00) begin
      errors++;
      $display("FAIL simul_commit_e15: got DB=%b Rise=%b Fall=%b Busy=%b, want 01 01 00 00", DB, Rise, Fall, Busy);
    end
    for (int e = 16; e <= 22; e++) begin
      tick();
      if (DB[1] || Rise[1] || Fall[1] || Busy[1]) ch1_bad++;
    end
    checks++;
    if (ch1_bad != 0) begin
      errors++;
      $display("FAIL simul_ch1_quiet: got %0d active cycles on ch1, want 0", ch1_bad);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      Din[1] = (i % 3 == 0);
      tick();
      if (DB[1] || Rise[1] || Fall[1]) bad++;
    end
    Din = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DB[1] || Rise[1] || Fall[1]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_ch1: got %0d cycles with DB/Rise/Fall high, want 0", bad);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Din   = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_reset_mid();
    test_simultaneous();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(posedge Clk) begin
    if (Rise[0] === 1'b1 && Fall[0] === 1'b1) begin
      errors++;
      $display("FAIL rise_fall_overlap_ch0: got Rise=1 Fall=1, want not both");
    end
  end

endmodule
